// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered one-hot / thermometer decoder with an auto-scan
// mode that walks a one-hot output through all 2^N positions, advancing one
// position every DVSR enabled cycles and pulsing tick on each advance.
module decoder_n_scan #(
  parameter int N    = 2,
  parameter int DVSR = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [N-1:0]         a,
  output logic [(1<<N)-1:0]    y,
  output logic [N-1:0]         idx,
  output logic                 tick
);

  localparam int W  = 1 << N;
  // A DVSR of 1 still needs a one-bit prescaler so the register exists.
  localparam int PW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DVSR - 1);

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [W-1:0]  y_q,     y_d;
  logic [N-1:0]  idx_q,   idx_d;
  logic          tick_q,  tick_d;
  logic [PW-1:0] presc_q, presc_d;
  mode_e         prevMode_q, prevMode_d;
  mode_e         modeIn;
  logic [N-1:0]  idxNext;

  function automatic logic [W-1:0] oneHot(input logic [N-1:0] sel);
    logic [W-1:0] v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] thermo(input logic [N-1:0] sel);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) begin
      v[i] = (i <= int'(sel));
    end
    return v;
  endfunction

  assign modeIn  = mode_e'(mode);
  assign idxNext = idx_q + 1'b1;

  // Next-state selection: blanking, decode modes, hold, and scan entry/continue/step.
  always_comb begin
    y_d        = y_q;
    idx_d      = idx_q;
    tick_d     = 1'b0;
    presc_d    = presc_q;
    prevMode_d = modeIn;
    if (!en) begin
      y_d = '0;
    end else begin
      case (modeIn)
        MODE_ONEHOT: begin
          y_d     = oneHot(a);
          idx_d   = a;
          presc_d = '0;
        end
        MODE_THERM: begin
          y_d     = thermo(a);
          idx_d   = a;
          presc_d = '0;
        end
        MODE_SCAN: begin
          if (prevMode_q != MODE_SCAN) begin
            y_d     = oneHot(a);
            idx_d   = a;
            presc_d = '0;
          end else if (presc_q == PRESC_MAX) begin
            y_d     = oneHot(idxNext);
            idx_d   = idxNext;
            presc_d = '0;
            tick_d  = 1'b1;
          end else begin
            y_d     = oneHot(idx_q);
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously while reset_n is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q        <= '0;
      idx_q      <= '0;
      tick_q     <= 1'b0;
      presc_q    <= '0;
      prevMode_q <= MODE_ONEHOT;
    end else begin
      y_q        <= y_d;
      idx_q      <= idx_d;
      tick_q     <= tick_d;
      presc_q    <= presc_d;
      prevMode_q <= prevMode_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Bench for decoder_n_scan. Two instances share the same stimulus: the
// default N=2/DVSR=4 build and an N=3/DVSR=1 build. Expected responses come
// from a behavioural model and are queued per instance; a monitor pops and
// compares after every clock edge. Directed scenarios add fixed-value checks.
module tb_decoder_n_scan;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [1:0] mode;
  logic [2:0] aIn;

  logic [3:0] y0;
  logic [1:0] idx0;
  logic       tick0;
  logic [7:0] y1;
  logic [2:0] idx1;
  logic       tick1;

  int compared;
  int mismatched;

  typedef struct {
    int y;
    int idx;
    int tick;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Model state, one slot per instance.
  int nBits[2] = '{2, 3};
  int dvsrs[2] = '{4, 1};
  int mY[2];
  int mIdx[2];
  int mPresc[2];
  int mPrev[2];
  int mTick[2];

  decoder_n_scan #(.N(2), .DVSR(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .a(aIn[1:0]),
    .y(y0), .idx(idx0), .tick(tick0)
  );

  decoder_n_scan #(.N(3), .DVSR(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .a(aIn),
    .y(y1), .idx(idx1), .tick(tick1)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model reset: everything cleared, previous mode back to one-hot decode.
  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mY[k] = 0; mIdx[k] = 0; mPresc[k] = 0; mPrev[k] = 0; mTick[k] = 0;
    end
  endtask

  // Behavioural reference: what one clock edge does to instance k, from the
  // block's rules (blank, decode, hold, scan entry, and scan stepping every
  // DVSR continued edges), then the expected outputs are queued.
  task automatic modelStep(input int k, input int e, input int md, input int av);
    int size;
    int sel;
    exp_t x;
    size = 1 << nBits[k];
    sel  = av % size;
    mTick[k] = 0;
    if (e == 0) begin
      mY[k] = 0;
    end else if (md == 0) begin
      mY[k] = 1 << sel; mIdx[k] = sel; mPresc[k] = 0;
    end else if (md == 1) begin
      mY[k] = (1 << (sel + 1)) - 1; mIdx[k] = sel; mPresc[k] = 0;
    end else if (md == 2) begin
      if (mPrev[k] != 2) begin
        mIdx[k] = sel; mPresc[k] = 0;
      end else if (mPresc[k] + 1 == dvsrs[k]) begin
        mPresc[k] = 0; mIdx[k] = (mIdx[k] + 1) % size; mTick[k] = 1;
      end else begin
        mPresc[k] = mPresc[k] + 1;
      end
      mY[k] = 1 << mIdx[k];
    end
    mPrev[k] = md;
    x.y = mY[k]; x.idx = mIdx[k]; x.tick = mTick[k];
    if (k == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // Drive one cycle's inputs on the falling edge, queue the model's
  // prediction, and return just after the following rising edge.
  task automatic applyStimulus(input int e, input int md, input int av);
    @(negedge clk);
    en   = e[0];
    mode = md[1:0];
    aIn  = av[2:0];
    modelStep(0, e, md, av);
    modelStep(1, e, md, av);
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and confirm the outputs clear without a clock.
  task automatic resetPulse();
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async reset y0", int'(y0), 0);
    checkOutput("async reset idx0", int'(idx0), 0);
    checkOutput("async reset tick0", int'(tick0), 0);
    checkOutput("async reset y1", int'(y1), 0);
    checkOutput("async reset idx1", int'(idx1), 0);
    checkOutput("async reset tick1", int'(tick1), 0);
    modelReset();
    #1 reset_n = 1'b1;
  endtask

  // Monitor: every edge produces an output word; compare against the queue.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      checkOutput("sb y0", int'(y0), x.y);
      checkOutput("sb idx0", int'(idx0), x.idx);
      checkOutput("sb tick0", int'(tick0), x.tick);
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      checkOutput("sb y1", int'(y1), x.y);
      checkOutput("sb idx1", int'(idx1), x.idx);
      checkOutput("sb tick1", int'(tick1), x.tick);
    end
  end

  // Main sequence: reset, directed scenarios, then randomized traffic.
  initial begin
    int ohTab[4]    = '{1, 2, 4, 8};
    int thermTab[4] = '{1, 3, 7, 15};
    int r;
    int md;
    compared   = 0;
    mismatched = 0;
    reset_n = 1'b0;
    en      = 1'b0;
    mode    = 2'b00;
    aIn     = 3'd0;
    modelReset();

    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset y0", int'(y0), 0);
    checkOutput("reset idx0", int'(idx0), 0);
    checkOutput("reset tick0", int'(tick0), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // One-hot decode over every select value.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, i);
      checkOutput("onehot y", int'(y0), ohTab[i]);
      checkOutput("onehot idx", int'(idx0), i);
      checkOutput("onehot tick", int'(tick0), 0);
    end

    // Thermometer decode, then blanking with idx held.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, i);
      checkOutput("therm y", int'(y0), thermTab[i]);
    end
    applyStimulus(0, 1, 0);
    checkOutput("blank y", int'(y0), 0);
    checkOutput("blank idx", int'(idx0), 3);

    // Scan from a=1: steps every 4 edges, wraps 3 -> 0, a ignored after entry.
    applyStimulus(1, 0, 1);
    for (int e = 0; e <= 12; e++) begin
      applyStimulus(1, 2, (e == 0) ? 1 : int'($urandom_range(0, 7)));
      checkOutput("scan y", int'(y0), ohTab[(1 + e / 4) % 4]);
      checkOutput("scan tick", int'(tick0), (e != 0 && e % 4 == 0) ? 1 : 0);
    end

    // Fresh scan, freeze after E5 for 3 cycles, then resume mid-prescale.
    applyStimulus(1, 0, 1);
    for (int e = 0; e <= 5; e++) applyStimulus(1, 2, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 2, 0);
      checkOutput("freeze y", int'(y0), 0);
      checkOutput("freeze idx", int'(idx0), 2);
      checkOutput("freeze tick", int'(tick0), 0);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 2, 0);
      checkOutput("resume tick", int'(tick0), (k == 2) ? 1 : 0);
      checkOutput("resume idx", int'(idx0), (k == 2) ? 3 : 2);
    end
    checkOutput("resume y", int'(y0), 8);

    // Hold mid-scan, then re-enter from a=3 and count a full period.
    applyStimulus(1, 2, 0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 3, 1);
      checkOutput("hold y", int'(y0), 8);
      checkOutput("hold idx", int'(idx0), 3);
      checkOutput("hold tick", int'(tick0), 0);
    end
    applyStimulus(1, 2, 3);
    checkOutput("reentry y", int'(y0), 8);
    checkOutput("reentry idx", int'(idx0), 3);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 2, 0);
      checkOutput("reentry tick", int'(tick0), (k == 3) ? 1 : 0);
    end
    checkOutput("reentry wrap y", int'(y0), 1);

    // Reset mid-scan, then the wide DVSR=1 instance enters at 5 and steps next edge.
    applyStimulus(1, 2, 0);
    applyStimulus(1, 2, 0);
    resetPulse();
    applyStimulus(1, 2, 5);
    checkOutput("wide entry y", int'(y1), 32);
    checkOutput("wide entry idx", int'(idx1), 5);
    checkOutput("wide entry tick", int'(tick1), 0);
    applyStimulus(1, 2, 5);
    checkOutput("wide step y", int'(y1), 64);
    checkOutput("wide step tick", int'(tick1), 1);

    // Randomized traffic, biased toward scanning, with occasional resets.
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 9));
      md = (r < 5) ? 2 : (r < 7) ? 0 : (r < 8) ? 1 : 3;
      applyStimulus(($urandom_range(0, 7) != 0) ? 1 : 0, md, int'($urandom_range(0, 7)));
      if ($urandom_range(0, 49) == 0) resetPulse();
    end

    @(posedge clk);
    #3;
    checkOutput("queue0 drained", q0.size(), 0);
    checkOutput("queue1 drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decoder_n_scan.md
DECODER_N_SCAN -- requirements
Module: decoder_n_scan

Interface
REQ-001 Parameter N, default 2: select width; output width is 2^N (legal N = 1..5).
REQ-002 Parameter DVSR, default 4: scan prescaler period in clock cycles (legal DVSR >= 1).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  enable; 0 forces a blank output and freezes the scan state.
REQ-006 mode  input  2  00 = one-hot decode, 01 = thermometer, 10 = auto-scan, 11 = hold.
REQ-007 a  input  N  select value, or scan start index.
REQ-008 y  output  2^N  registered decoded output.
REQ-009 idx  output  N  registered index currently represented on y.
REQ-010 tick  output  1  registered one-cycle pulse on each scan step.

Function
REQ-011 y, idx and tick SHALL all be registers, with 1 clock edge of latency from the inputs.
REQ-012 en=0: at the next edge, y SHALL become 0 and tick SHALL become 0; idx and the prescaler SHALL hold.
REQ-013 en=1, mode=00: at the next edge, y SHALL take bit a set and all other bits clear, and idx SHALL take the value a.
REQ-014 en=1, mode=01: at the next edge, y bits 0..a SHALL be 1 and all higher bits 0 (for example, a=2 gives y=0111), and idx SHALL take the value a.
REQ-015 In modes 00 and 01, the prescaler SHALL be cleared to 0 and tick SHALL be 0.
REQ-016 en=1, mode=11: y, idx and the prescaler SHALL hold their values, and tick SHALL be 0.
REQ-017 The block SHALL keep a registered copy of the previous mode, updated on every edge regardless of en.
REQ-018 Scan entry: an edge with en=1, mode=10 and previous mode not equal to 10 is a scan entry.
REQ-019 At scan entry, idx SHALL be loaded with a, the prescaler cleared to 0, y set to the one-hot code of a, and tick set to 0.
REQ-020 On a scan-continue edge (en=1, mode=10, previous mode 10) with prescaler < DVSR-1, the prescaler SHALL increment, and idx, y and tick SHALL stay unchanged except that tick=0.
REQ-021 On a scan-continue edge with prescaler = DVSR-1:
- prescaler SHALL go to 0;
- idx SHALL go to idx+1 modulo 2^N (2^N-1 wraps to 0);
- y SHALL take the one-hot code of the new idx;
- tick SHALL be 1 for exactly that one cycle.
REQ-022 With DVSR=1, the block SHALL step the scan on every scan-continue edge, so tick is continuously 1.
REQ-023 The prescaler width SHALL be ceil(log2(DVSR)) bits, with a minimum of 1, and it SHALL never exceed DVSR-1.
REQ-024 In mode 10, y SHALL always equal the one-hot code of idx, except while en=0.
REQ-025 en=0 followed by en=1 with mode held at 10 SHALL resume the scan from the frozen idx and prescaler; it SHALL NOT count as a scan entry.
REQ-026 A transition from mode 11 to mode 10 SHALL count as a scan entry and reload idx from a.
REQ-027 Changes to a during scan-continue edges SHALL have no effect.

Reset
REQ-028 While reset_n=0, asynchronously and independent of clk, y SHALL be 0, idx 0, tick 0, the prescaler 0, and the previous-mode register 00.
REQ-029 Reset asserted mid-scan SHALL abort the scan.
REQ-030 After reset is released with mode=10 and en=1, the first edge SHALL be a scan entry.

Verification
REQ-031 Bench: N=2, DVSR=4, en=1, mode=00, a=0..3 over successive cycles -> y=0001, 0010, 0100, 1000 one edge later; idx tracks a; tick=0 throughout.
REQ-032 Bench: mode=01, a=0,1,2,3 -> y=0001, 0011, 0111, 1111; then en=0 -> y=0000 at the next edge, idx unchanged.
REQ-033 Bench: mode 00 changed to 10 with a=1 (entry edge E0) -> y=0010 at E0; y=0100 with tick=1 at E4; y=1000 at E8; y=0001 (wrap) at E12; tick high only at E4, E8 and E12.
REQ-034 Bench: during the scan, en=0 for 3 cycles starting after E5 -> y=0000, idx=2 held; on en=1 the step occurs 3 enabled edges later (prescaler resumes at 1), with no reload from a.
REQ-035 Bench: mode=11 mid-scan -> y and idx frozen; then mode=10 with a=3 -> y=1000 and idx=3 at the next edge, and the next step occurs 4 edges after that.
REQ-036 Bench: reset_n pulsed low between clock edges during the scan -> y, idx and tick go to 0 immediately; after release, N=3, DVSR=1, a=5 -> y=00100000, then the step to 01000000 with tick=1 at the following edge.
